// File: rtl/peripheral_bus_arbiter.sv
// Two-master round-robin arbiter for the shared peripheral bus; grant is locked per transaction.
// Optional forced release on a stuck peripheral: define PERIPHERAL_BUS_ARBITER_TIMEOUT_EN.
module peripheral_bus_arbiter #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,

    input  logic                     masterA_we,
    input  logic                     masterA_oe,
    output logic                     masterA_busy,
    input  logic [ADDRESS_WIDTH-1:0] masterA_address,
    input  logic [3:0]               masterA_byteSelect,
    input  logic [DATA_WIDTH-1:0]    masterA_dataWrite,
    output logic [DATA_WIDTH-1:0]    masterA_dataRead,

    input  logic                     masterB_we,
    input  logic                     masterB_oe,
    output logic                     masterB_busy,
    input  logic [ADDRESS_WIDTH-1:0] masterB_address,
    input  logic [3:0]               masterB_byteSelect,
    input  logic [DATA_WIDTH-1:0]    masterB_dataWrite,
    output logic [DATA_WIDTH-1:0]    masterB_dataRead,

    output logic                     peripheralBus_we,
    output logic                     peripheralBus_oe,
    input  logic                     peripheralBus_busy,
    output logic [ADDRESS_WIDTH-1:0] peripheralBus_address,
    output logic [3:0]               peripheralBus_byteSelect,
    output logic [DATA_WIDTH-1:0]    peripheralBus_dataWrite,
    input  logic [DATA_WIDTH-1:0]    peripheralBus_dataRead,

    output logic [1:0]               grant,
    output logic                     timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   lastGrantB_q, lastGrantB_d;
    logic   reqA, reqB;
    logic   timeout_w;

    assign reqA = masterA_we | masterA_oe;
    assign reqB = masterB_we | masterB_oe;

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_w = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Entry covers both IDLE->GRANT and direct handover between masters.
    always_comb begin
        cnt_d = '0;
        if ((state_q != IDLE) && (state_d == state_q) && peripheralBus_busy) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign timeout_w = 1'b0;
`endif

    assign timeout_o = timeout_w;

    always_comb begin
        state_d      = state_q;
        lastGrantB_d = lastGrantB_q;
        unique case (state_q)
            IDLE: begin
                if (reqA && reqB) begin
                    state_d = lastGrantB_q ? GRANT_A : GRANT_B;
                end else if (reqA) begin
                    state_d = GRANT_A;
                end else if (reqB) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!reqA) begin
                    state_d = reqB ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (!reqB) begin
                    state_d = reqA ? GRANT_A : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout_w) begin
            state_d = IDLE;
        end

        if (state_d == GRANT_A) begin
            lastGrantB_d = 1'b0;
        end else if (state_d == GRANT_B) begin
            lastGrantB_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= IDLE;
            lastGrantB_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lastGrantB_q <= lastGrantB_d;
        end
    end

    assign grant = {state_q == GRANT_B, state_q == GRANT_A};

    always_comb begin
        peripheralBus_we         = 1'b0;
        peripheralBus_oe         = 1'b0;
        peripheralBus_address    = '0;
        peripheralBus_byteSelect = '0;
        peripheralBus_dataWrite  = '0;
        masterA_dataRead         = '0;
        masterB_dataRead         = '0;
        masterA_busy             = reqA;
        masterB_busy             = reqB;

        unique case (state_q)
            GRANT_A: begin
                peripheralBus_we         = masterA_we;
                peripheralBus_oe         = masterA_oe;
                peripheralBus_address    = masterA_address;
                peripheralBus_byteSelect = masterA_byteSelect;
                peripheralBus_dataWrite  = masterA_dataWrite;
                masterA_busy             = peripheralBus_busy & ~timeout_w;
                if (timeout_w) begin
                    masterA_dataRead = '1;
                end else if (masterA_oe) begin
                    masterA_dataRead = peripheralBus_dataRead;
                end
            end
            GRANT_B: begin
                peripheralBus_we         = masterB_we;
                peripheralBus_oe         = masterB_oe;
                peripheralBus_address    = masterB_address;
                peripheralBus_byteSelect = masterB_byteSelect;
                peripheralBus_dataWrite  = masterB_dataWrite;
                masterB_busy             = peripheralBus_busy & ~timeout_w;
                if (timeout_w) begin
                    masterB_dataRead = '1;
                end else if (masterB_oe) begin
                    masterB_dataRead = peripheralBus_dataRead;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed bench for peripheral_bus_arbiter; timeout section runs when PERIPHERAL_BUS_ARBITER_TIMEOUT_EN is defined.
module tb_peripheral_bus_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_we, a_oe, a_busy, b_we, b_oe, b_busy;
    logic [AW-1:0] a_addr, b_addr, p_addr;
    logic [3:0]    a_bs, b_bs, p_bs;
    logic [DW-1:0] a_dw, b_dw, a_dr, b_dr, p_dw, p_dr;
    logic          p_we, p_oe, p_busy, timeout;
    logic [1:0]    grant;

    int checks = 0;
    int errors = 0;

    peripheral_bus_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .wb_clk_i                (clk),
        .wb_rst_n_i              (rst_n),
        .masterA_we              (a_we),
        .masterA_oe              (a_oe),
        .masterA_busy            (a_busy),
        .masterA_address         (a_addr),
        .masterA_byteSelect      (a_bs),
        .masterA_dataWrite       (a_dw),
        .masterA_dataRead        (a_dr),
        .masterB_we              (b_we),
        .masterB_oe              (b_oe),
        .masterB_busy            (b_busy),
        .masterB_address         (b_addr),
        .masterB_byteSelect      (b_bs),
        .masterB_dataWrite       (b_dw),
        .masterB_dataRead        (b_dr),
        .peripheralBus_we        (p_we),
        .peripheralBus_oe        (p_oe),
        .peripheralBus_busy      (p_busy),
        .peripheralBus_address   (p_addr),
        .peripheralBus_byteSelect(p_bs),
        .peripheralBus_dataWrite (p_dw),
        .peripheralBus_dataRead  (p_dr),
        .grant                   (grant),
        .timeout_o               (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock, then settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
    localparam int BUSY_HOLD = 3;
`else
    localparam int BUSY_HOLD = 5;
`endif

    logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        {a_we, a_oe, b_we, b_oe, p_busy} = '0;
        a_addr = '0; b_addr = '0; a_bs = '0; b_bs = '0;
        a_dw = '0; b_dw = '0; p_dr = '0;
        rst_n = 1'b0;
        #3;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_p_we", 32'(p_we), 32'h0);
        check("rst_p_addr", 32'(p_addr), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        do_reset();

        // A single write
        a_we = 1'b1; a_addr = 24'h000010; a_dw = 32'hDEADBEEF; a_bs = 4'hF;
        #1;
        check("w_pre_grant", 32'(grant), 32'h0);
        check("w_pre_busyA", 32'(a_busy), 32'h1);
        tick();
        check("w_grant", 32'(grant), 32'h1);
        check("w_p_we", 32'(p_we), 32'h1);
        check("w_p_addr", 32'(p_addr), 32'h000010);
        check("w_p_dw", p_dw, 32'hDEADBEEF);
        check("w_p_bs", 32'(p_bs), 32'hF);
        check("w_busyA", 32'(a_busy), 32'h0);
        a_we = 1'b0;
        tick();
        check("w_release", 32'(grant), 32'h0);

        // Simultaneous reads after reset: A wins, then direct handover to B
        do_reset();
        a_oe = 1'b1; b_oe = 1'b1; b_addr = 24'h000020; p_dr = 32'h12345678;
        tick();
        check("rd_grantA", 32'(grant), 32'h1);
        check("rd_busyB", 32'(b_busy), 32'h1);
        check("rd_drA", a_dr, 32'h12345678);
        check("rd_drB_nonowner", b_dr, 32'h0);
        a_oe = 1'b0;
        #1;
        check("rd_busyB_handover", 32'(b_busy), 32'h1);
        tick();
        check("rd_grantB", 32'(grant), 32'h2);
        check("rd_busyB_owned", 32'(b_busy), 32'h0);
        check("rd_drB", b_dr, 32'h12345678);
        check("rd_drA_nonowner", a_dr, 32'h0);
        check("rd_p_addr", 32'(p_addr), 32'h000020);

        // B holds the bus through a long peripheral stall while A waits
        p_busy = 1'b1; a_we = 1'b1;
        for (int i = 0; i < BUSY_HOLD; i++) begin
            tick();
            check("st_grantB", 32'(grant), 32'h2);
            check("st_busyB", 32'(b_busy), 32'h1);
            check("st_busyA", 32'(a_busy), 32'h1);
            check("st_timeout", 32'(timeout), 32'h0);
        end
        p_busy = 1'b0;
        #1;
        check("st_busyB_ready", 32'(b_busy), 32'h0);
        b_oe = 1'b0;
        #1;
        check("st_busyA_wait", 32'(a_busy), 32'h1);
        tick();
        check("st_grantA", 32'(grant), 32'h1);
        check("st_busyA_owned", 32'(a_busy), 32'h0);

        // Back-to-back alternation under contention
        a_we = 1'b0; a_oe = 1'b1; b_oe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p_dr = 32'hCAFE0000 + 32'(i);
            #1;
            check("rr_grant", 32'(grant), 32'(exp_order[i]));
            if (exp_order[i] == 2'b01) begin
                check("rr_drA_owner", a_dr, 32'hCAFE0000 + 32'(i));
                check("rr_drB_nonowner", b_dr, 32'h0);
                a_oe = 1'b0;
                tick();
                a_oe = 1'b1;
            end else begin
                check("rr_drB_owner", b_dr, 32'hCAFE0000 + 32'(i));
                check("rr_drA_nonowner", a_dr, 32'h0);
                b_oe = 1'b0;
                tick();
                b_oe = 1'b1;
            end
        end
        a_oe = 1'b0; b_oe = 1'b0;
        tick();
        check("rr_idle", 32'(grant), 32'h0);

        // Asynchronous reset in the middle of a write
        a_we = 1'b1; a_addr = 24'hABCDEF; a_dw = 32'h55AA55AA;
        tick();
        check("ar_grant", 32'(grant), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_p_we", 32'(p_we), 32'h0);
        check("ar_p_addr", 32'(p_addr), 32'h0);
        check("ar_p_dw", p_dw, 32'h0);
        check("ar_grant0", 32'(grant), 32'h0);
        a_we = 1'b0;
        tick();
        rst_n = 1'b1;
        b_we = 1'b1; b_addr = 24'h000044; b_dw = 32'h0BADF00D;
        tick();
        check("ar_after_grant", 32'(grant), 32'h2);
        check("ar_after_p_dw", p_dw, 32'h0BADF00D);
        b_we = 1'b0;
        tick();

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
        // Stuck peripheral forces release after 4 busy cycles
        do_reset();
        a_oe = 1'b1; b_oe = 1'b1; p_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_grantA", 32'(grant), 32'h1);
            check("to_busyA", 32'(a_busy), 32'h1);
            check("to_pulse_low", 32'(timeout), 32'h0);
        end
        tick();
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_busyA_forced", 32'(a_busy), 32'h0);
        check("to_drA", a_dr, 32'hFFFFFFFF);
        tick();
        check("to_idle", 32'(grant), 32'h0);
        check("to_pulse_end", 32'(timeout), 32'h0);
        tick();
        check("to_grantB", 32'(grant), 32'h2);
        a_oe = 1'b0; b_oe = 1'b0; p_busy = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/peripheral_bus_arbiter.md
Name: peripheral_bus_arbiter

Overview:
Two-master arbiter that shares a single peripheral bus (we/oe/busy/address/byteSelect/dataWrite/dataRead) between requesters.
- Requesters: e.g. the Wishbone-to-peripheral-bus interface and a second on-chip master (DMA or core-local port).
- Grant is locked for the whole transaction and alternates round-robin on contention.
- Sits between the bus masters and the peripheral decode/mux.

Parameters:
ADDRESS_WIDTH, 24, peripheral bus address width
DATA_WIDTH, 32, peripheral bus data width
TIMEOUT_CYCLES, 255, max cycles a granted transaction may see busy before forced release (optional feature only)

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous active-low reset
masterA_we  in  1  master A write request
masterA_oe  in  1  master A read request
masterA_busy  out  1  wait/stall to master A
masterA_address  in  ADDRESS_WIDTH  master A address
masterA_byteSelect  in  4  master A byte lanes
masterA_dataWrite  in  DATA_WIDTH  master A write data
masterA_dataRead  out  DATA_WIDTH  read data to master A
masterB_*  same set as master A, for master B
peripheralBus_we  out  1  shared bus write strobe
peripheralBus_oe  out  1  shared bus read strobe
peripheralBus_busy  in  1  peripheral wait
peripheralBus_address  out  ADDRESS_WIDTH  shared address
peripheralBus_byteSelect  out  4  shared byte lanes
peripheralBus_dataWrite  out  DATA_WIDTH  shared write data
peripheralBus_dataRead  in  DATA_WIDTH  shared read data
grant  out  2  one-hot current owner {B,A}; 00 = idle
timeout_o  out  1  one-cycle pulse on forced release (optional feature only; 0 otherwise)

Behaviour:
- Request definitions: reqA = masterA_we | masterA_oe; reqB likewise. Asserting we and oe together is illegal; the arbiter forwards both unchanged.
- Reset (async assert, sync release):
  - state=IDLE, lastGrant=B (so A wins the first tie).
  - grant=00, timeout_o=0; all peripheralBus_* outputs 0.
- States: IDLE, GRANT_A, GRANT_B; one-hot grant is decoded from state.
- IDLE:
  - reqA only -> GRANT_A; reqB only -> GRANT_B.
  - Both -> the master not equal to lastGrant.
  - Decision is registered: one cycle from request to grant.
- GRANT_X:
  - While reqX stays high, remain in GRANT_X (locked); lastGrant<=X on entry.
  - When reqX drops: next = GRANT_other if req_other, else IDLE. Direct handover, no idle bubble.
- Shared bus mux (combinational from state):
  - GRANT_X: peripheralBus_we/oe/address/byteSelect/dataWrite = master X's signals.
  - IDLE: all zero.
- Busy:
  - masterX_busy = (reqX & state!=GRANT_X) | (state==GRANT_X & peripheralBus_busy).
  - A requester never sees busy low until it owns the bus and the peripheral is ready.
- Read data:
  - masterX_dataRead = peripheralBus_dataRead when state==GRANT_X & masterX_oe, else 0.
  - The non-owner always reads 0.
- A requester withdrawing before grant (drops req while waiting) is legal; no grant is issued to it.
- Reset mid-transaction: bus outputs drop to 0 immediately (async) and the transaction is abandoned. Masters are reset on the same net.
- Starvation bound: with both masters continuously requesting, the waiting master is granted within one cycle of the current owner dropping its request.

Optional Feature:
Macro PERIPHERAL_BUS_ARBITER_TIMEOUT_EN.
- Enabled:
  - An 8..16-bit counter (sized to TIMEOUT_CYCLES) clears on each grant entry and on every cycle with peripheralBus_busy=0.
  - It increments while state==GRANT_X and peripheralBus_busy=1.
  - On reaching TIMEOUT_CYCLES: masterX_busy forced 0 for one cycle with masterX_dataRead=32'hFFFFFFFF, and timeout_o pulses for one cycle.
  - State then goes to IDLE and lastGrant=X.
- Disabled: no counter; timeout_o tied 0; ownership is held indefinitely while busy.

Test Plan:
- Reset released, A writes addr 24'h000010 data 32'hDEADBEEF, peripheral busy=0 -> grant=01 on the following cycle. peripheralBus_we=1 with A's address/data. masterA_busy=0 from the grant cycle; grant=00 after A drops we.
- A and B request reads in the same cycle from IDLE after reset -> A granted first. B sees busy=1 until A drops oe, then grant=10 on the next cycle with no IDLE cycle between. B receives peripheralBus_dataRead=32'h12345678.
- B granted, peripheral busy held high 5 cycles, A requesting -> bus stays with B. masterB_busy=1 for 5 cycles. masterA_busy=1 throughout; A granted only after B releases.
- Alternating back-to-back contention for 4 transactions -> grant order A,B,A,B. masterX_dataRead for the non-owner is always 0.
- Reset asserted while grant=01 with we=1 -> peripheralBus_we/address/dataWrite go 0 asynchronously and grant=00. First request after release is served normally.
- (TIMEOUT_EN, TIMEOUT_CYCLES=4) A reads, peripheral busy stuck 1 -> after 4 busy cycles, masterA_busy=0 for one cycle with dataRead=32'hFFFFFFFF and timeout_o=1 for one cycle. State returns to IDLE, and a pending B request is granted next.
